// File: rtl/cdb_result_queue.sv
// FIFO result buffer between a functional unit and the CDB scheduler (valid_out/yumi_in transmitter).
// Optional CDB_RQ_BYPASS_EN: an empty queue forwards din to dout in the same cycle.
package cdb_result_queue_pkg;
  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] value;
  } cdb_packet_t;
endpackage

module cdb_result_queue
  import cdb_result_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     valid_in,
  input  cdb_packet_t              din,
  output logic                     ready,
  output logic                     valid_out,
  output cdb_packet_t              dout,
  input  logic                     yumi_in,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  cdb_packet_t           mem_q [DEPTH];
  logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  err_q, err_d;
  logic                  clear, stored, bypass, bypass_take, enq, deq;

  assign clear  = reset | flush;
  assign stored = (count_q != '0);
  assign ready  = (count_q < FullCount);

`ifdef CDB_RQ_BYPASS_EN
  assign bypass = ~stored & valid_in & ~clear;
`else
  assign bypass = 1'b0;
`endif

  assign valid_out   = stored | bypass;
  assign bypass_take = bypass & yumi_in;

  always_comb begin
    dout = '0;
    if (stored) begin
      dout = mem_q[head_q];
    end else if (bypass) begin
      dout = din;
    end
  end

  // A bypassed packet granted in the same cycle never touches the buffer.
  assign enq = ~clear & valid_in & ready & ~bypass_take;
  assign deq = ~clear & yumi_in & stored;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + PtrW'(1);
      if (deq) head_d = head_q + PtrW'(1);
      unique case ({enq, deq})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
      if ((valid_in & ~ready) | (yumi_in & ~valid_out)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= din;
  end

  assign count = count_q;
  assign err   = err_q;

endmodule

// File: tb/tb_cdb_result_queue.sv
// Self-checking bench for cdb_result_queue: vector table plus a streaming scoreboard.
module tb_cdb_result_queue;
  import cdb_result_queue_pkg::*;

`ifdef CDB_RQ_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, valid_in, yumi_in;
  cdb_packet_t din, dout;
  logic        ready, valid_out, err;
  logic [1:0]  count;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  cdb_result_queue #(.DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .valid_in  (valid_in),
    .din       (din),
    .ready     (ready),
    .valid_out (valid_out),
    .dout      (dout),
    .yumi_in   (yumi_in),
    .count     (count),
    .err       (err)
  );

  typedef struct {
    logic        rst, fl, vin, yumi;
    cdb_packet_t pkt;
    logic        e_vout;
    cdb_packet_t e_dout;
    logic        e_ready;
    logic [1:0]  e_count;
    logic        e_err;
  } vec_t;

  localparam int NVec = 25;
  vec_t vecs [NVec];

  cdb_packet_t sb [$];
  int          sb_cyc [$];

  function automatic cdb_packet_t pk(input int t, input int v);
    cdb_packet_t p;
    p.tag   = 6'(t);
    p.value = 32'(v);
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic setv(input int i, input logic rst, input logic fl, input logic vin,
                      input cdb_packet_t pkt, input logic yumi, input logic ev,
                      input cdb_packet_t ed, input logic er, input logic [1:0] ec,
                      input logic ee);
    vecs[i] = '{rst: rst, fl: fl, vin: vin, yumi: yumi, pkt: pkt, e_vout: ev,
                e_dout: ed, e_ready: er, e_count: ec, e_err: ee};
  endtask

  initial begin
    cdb_packet_t z, p11, p22, p33, p44, p55, p66;
    z   = '0;
    p11 = pk(3, 'h11);
    p22 = pk(5, 'h22);
    p33 = pk(7, 'h33);
    p44 = pk(1, 'h44);
    p55 = pk(2, 'h55);
    p66 = pk(4, 'h66);

    // Each row: inputs held for one cycle, outputs expected in that same cycle (pre-edge).
    //      i   rst fl vin pkt  yumi vout  dout                ready cnt err
    setv( 0, 0, 0, 0, z,   0, 0,   z,                  1, 0, 0);
    setv( 1, 0, 0, 1, p11, 0, Byp, Byp ? p11 : z,      1, 0, 0);
    setv( 2, 0, 0, 1, p22, 0, 1,   p11,                1, 1, 0);
    setv( 3, 0, 0, 0, z,   0, 1,   p11,                0, 2, 0);
    setv( 4, 0, 0, 0, z,   1, 1,   p11,                0, 2, 0);
    setv( 5, 0, 0, 0, z,   0, 1,   p22,                1, 1, 0);
    setv( 6, 0, 0, 1, p33, 0, 1,   p22,                1, 1, 0);
    setv( 7, 0, 0, 1, p44, 1, 1,   p22,                0, 2, 0); // push while full
    setv( 8, 0, 0, 0, z,   0, 1,   p33,                1, 1, 1);
    setv( 9, 1, 0, 0, z,   0, 1,   p33,                1, 1, 1);
    setv(10, 0, 0, 0, z,   0, 0,   z,                  1, 0, 0);
    setv(11, 0, 0, 1, p11, 0, Byp, Byp ? p11 : z,      1, 0, 0);
    setv(12, 0, 0, 1, p22, 0, 1,   p11,                1, 1, 0);
    setv(13, 0, 0, 0, z,   1, 1,   p11,                0, 2, 0); // yumi at full, ready honoured
    setv(14, 0, 0, 1, p33, 1, 1,   p22,                1, 1, 0);
    setv(15, 0, 0, 0, z,   0, 1,   p33,                1, 1, 0);
    setv(16, 0, 0, 1, p44, 0, 1,   p33,                1, 1, 0);
    setv(17, 0, 1, 1, p55, 0, 1,   p33,                0, 2, 0); // flush drops 0x55
    setv(18, 0, 0, 0, z,   0, 0,   z,                  1, 0, 0);
    setv(19, 0, 0, 0, z,   1, 0,   z,                  1, 0, 0); // yumi while empty
    setv(20, 0, 0, 0, z,   0, 0,   z,                  1, 0, 1);
    setv(21, 0, 1, 0, z,   0, 0,   z,                  1, 0, 1);
    setv(22, 0, 0, 1, p66, 0, Byp, Byp ? p66 : z,      1, 0, 1);
    setv(23, 1, 0, 0, z,   0, 1,   p66,                1, 1, 1);
    setv(24, 0, 0, 0, z,   0, 0,   z,                  1, 0, 0);

    reset = 1'b1; flush = 1'b0; valid_in = 1'b0; yumi_in = 1'b0; din = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NVec; i++) begin
      #1;
      reset    = vecs[i].rst;
      flush    = vecs[i].fl;
      valid_in = vecs[i].vin;
      din      = vecs[i].pkt;
      yumi_in  = vecs[i].yumi;
      @(negedge clk);
      check($sformatf("v%0d.valid_out", i), 64'(valid_out), 64'(vecs[i].e_vout));
      check($sformatf("v%0d.dout", i),      64'(dout),      64'(vecs[i].e_dout));
      check($sformatf("v%0d.ready", i),     64'(ready),     64'(vecs[i].e_ready));
      check($sformatf("v%0d.count", i),     64'(count),     64'(vecs[i].e_count));
      check($sformatf("v%0d.err", i),       64'(err),       64'(vecs[i].e_err));
      @(posedge clk);
    end

    // Streaming: grant whenever offered; 8 packets wrap the 2-entry buffer several times.
    #1;
    reset = 1'b0; flush = 1'b0; valid_in = 1'b0; yumi_in = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      valid_in = (c < 8);
      din      = (c < 8) ? pk(c, 'hA0 + c) : '0;
      if (c < 8) begin
        sb.push_back(din);
        sb_cyc.push_back(c + (Byp ? 0 : 1));
      end
      #1;
      yumi_in = valid_out;
      @(negedge clk);
      check($sformatf("s%0d.ready", c), 64'(ready), 64'(1));
      if (valid_out && yumi_in) begin
        if (sb.size() == 0) begin
          check($sformatf("s%0d.spurious", c), 64'(dout), 64'(0));
        end else begin
          check($sformatf("s%0d.dout", c),  64'(dout), 64'(sb.pop_front()));
          check($sformatf("s%0d.cycle", c), 64'(c),    64'(sb_cyc.pop_front()));
        end
      end
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0; yumi_in = 1'b0;
    @(negedge clk);
    check("stream.drained", 64'(sb.size()), 64'(0));
    check("stream.count",   64'(count),     64'(0));
    check("stream.err",     64'(err),       64'(0));
    check("stream.valid",   64'(valid_out), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
